// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding memory read, DEPTH-entry {pc, instr} queue to decode.
// Word visible one cycle after i_mem_ready; fetch stalls when the queue is full or a redirect target is misaligned.
module instr_prefetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  output logic            o_misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] stale_pc_q, stale_pc_d;
  logic            mis_q, mis_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic            push, pop;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= PC_RESET;
      stale_pc_q <= PC_RESET;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_pc_q <= stale_pc_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      mem_q      <= mem_d;
    end
  end

  // Queue and fetch-PC update; a redirect overrides any push or pop in the same cycle.
  always_comb begin
    push       = (state_q == REQ) && i_mem_ready && !i_redirect;
    pop        = (cnt_q != '0) && i_ready && !i_redirect;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    fetch_pc_d = fetch_pc_q;
    stale_pc_d = stale_pc_q;
    mis_d      = mis_q;
    if (push) begin
      mem_d[wr_q] = '{pc: fetch_pc_q, instr: i_mem_data};
      wr_d        = wr_q + AW'(1);
      fetch_pc_d  = fetch_pc_q + XLEN'(4);
    end
    if (pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // The abandoned request keeps presenting its original address until memory completes it.
    if ((state_q == REQ) && !i_mem_ready && i_redirect) stale_pc_d = fetch_pc_q;
    if (i_redirect) begin
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      fetch_pc_d = i_redirect_pc;
      mis_d      = |i_redirect_pc[1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_redirect)                       state_d = (|i_redirect_pc[1:0]) ? IDLE : REQ;
        else if (!mis_q && (cnt_q < FULL))    state_d = REQ;
      end
      REQ: begin
        if (i_mem_ready)                      state_d = (!i_redirect && (cnt_d < FULL)) ? REQ : IDLE;
        else if (i_redirect)                  state_d = DISCARD;
      end
      DISCARD: begin
        if (i_mem_ready)                      state_d = IDLE;
      end
      default:                                state_d = IDLE;
    endcase
  end

  always_comb begin
    o_mem_req    = (state_q != IDLE);
    o_mem_addr   = (state_q == DISCARD) ? stale_pc_q : fetch_pc_q;
    o_valid      = (cnt_q != '0);
    o_instr      = mem_q[rd_q].instr;
    o_instr_pc   = mem_q[rd_q].pc;
    o_misaligned = mis_q;
  end

endmodule
